// File: rtl/clk_div_pkg.sv
// Shared types and sizing helpers for the clock divider configuration front-end.
package clk_div_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GATE      = 3'd1,
        APPLY     = 3'd2,
        WAIT_DONE = 3'd3,
        FINISH    = 3'd4
    } clk_div_cfg_state_e;

    localparam int STATE_W = $bits(clk_div_cfg_state_e);

    localparam int DFLT_GATE_CYCLES    = 2;
    localparam int DFLT_TIMEOUT_CYCLES = 1024;

    // Counter width for a count of 'cycles': one spare bit so the last count never wraps.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

    localparam int DFLT_GATE_CNT_W = cnt_width(DFLT_GATE_CYCLES);
    localparam int DFLT_TMO_CNT_W  = cnt_width(DFLT_TIMEOUT_CYCLES);

endpackage

// File: rtl/clk_div_cfg_tmo_cnt.sv
// Saturating cycle counter with clear and enable; expire_o marks the last of LIMIT counts.
module clk_div_cfg_tmo_cnt
    import clk_div_pkg::*;
#(
    parameter int LIMIT = 2,
    parameter int WIDTH = cnt_width(LIMIT)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_q;

    // Holds at LAST until cleared, so a stalled owner keeps seeing expire.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    dffr #(.WIDTH(WIDTH), .RST_VAL('0)) u_cnt_ff (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (cnt_d),
        .q_o     (cnt_q)
    );

    assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/dffr.sv
// Generic D flop with asynchronous active-low reset to a parameterised value.
module dffr #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Configuration front-end for clk_int_div_simple: registers the divide value, gates the
// divided clock around each change and sequences the divider handshake and done wait.
module clk_div_cfg_ctrl
    import clk_div_pkg::*;
#(
    parameter int                         DIV_VALUE_WIDTH = 32,
    parameter logic [DIV_VALUE_WIDTH-1:0] DIV_RST_VAL     = '0,
    parameter int                         GATE_CYCLES     = DFLT_GATE_CYCLES,
    parameter int                         TIMEOUT_CYCLES  = DFLT_TIMEOUT_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
    input  logic                       cfg_init_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    output logic [DIV_VALUE_WIDTH-1:0] div_o,
    output logic                       clk_init_o,
    output logic                       div_valid_o,
    input  logic                       div_ready_i,
    input  logic                       div_done_i,
    output logic                       clk_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       timeout_o
);

    localparam int GATE_CNT_W = cnt_width(GATE_CYCLES);
    localparam int TMO_CNT_W  = cnt_width(TIMEOUT_CYCLES);

    // {clk_en, div_valid, busy, done, wait_first}
    localparam int          OUT_W       = 5;
    localparam logic [4:0]  OUT_RST_VAL = 5'b10000;

    clk_div_cfg_state_e         state_d;
    clk_div_cfg_state_e         state_q;
    logic [STATE_W-1:0]         state_bits_q;

    logic [DIV_VALUE_WIDTH-1:0] div_d;
    logic [DIV_VALUE_WIDTH-1:0] div_q;
    logic                       init_d;
    logic                       init_q;
    logic [DIV_VALUE_WIDTH-1:0] shadow_div_d;
    logic [DIV_VALUE_WIDTH-1:0] shadow_div_q;
    logic                       shadow_init_d;
    logic                       shadow_init_q;
    logic                       timeout_d;
    logic                       timeout_q;

    logic                       clk_en_d;
    logic                       clk_en_q;
    logic                       div_valid_d;
    logic                       div_valid_q;
    logic                       busy_d;
    logic                       busy_q;
    logic                       done_d;
    logic                       done_q;
    logic                       wait_first_d;
    logic                       wait_first_q;

    logic                       accept;
    logic                       gate_expire;
    logic                       tmo_expire;

    assign state_q     = clk_div_cfg_state_e'(state_bits_q);
    assign cfg_ready_o = (state_q == IDLE);
    assign accept      = cfg_valid_i && cfg_ready_o;

    // Next-state and data-register update; div_o changes only on the GATE -> APPLY edge.
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        init_d        = init_q;
        shadow_div_d  = shadow_div_q;
        shadow_init_d = shadow_init_q;
        timeout_d     = timeout_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shadow_div_d  = cfg_div_i;
                    shadow_init_d = cfg_init_i;
                    timeout_d     = 1'b0;
                    if ((cfg_div_i == div_q) && (cfg_init_i == init_q)) begin
                        state_d = FINISH;
                    end else begin
                        state_d = GATE;
                    end
                end
            end
            GATE: begin
                if (gate_expire) begin
                    state_d = APPLY;
                    div_d   = shadow_div_q;
                    init_d  = shadow_init_q;
                end
            end
            APPLY: begin
                if (div_ready_i) begin
                    // A bypass divider never reports done, so skip the wait.
                    state_d = (shadow_div_q != '0) ? WAIT_DONE : FINISH;
                end
            end
            WAIT_DONE: begin
                if (div_done_i && !wait_first_q) begin
                    state_d = FINISH;
                end else if (tmo_expire) begin
                    timeout_d = 1'b1;
                    state_d   = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are decoded from the next state and registered, keeping clk_en glitch-free.
    always_comb begin
        clk_en_d     = !((state_d == GATE) || (state_d == APPLY) || (state_d == WAIT_DONE));
        div_valid_d  = (state_d == APPLY);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH);
        wait_first_d = (state_q == APPLY) && (state_d == WAIT_DONE);
    end

    dffr #(.WIDTH(STATE_W), .RST_VAL(IDLE)) u_state_ff (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (state_d),
        .q_o     (state_bits_q)
    );

    dffr #(.WIDTH(DIV_VALUE_WIDTH), .RST_VAL(DIV_RST_VAL)) u_div_ff (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (div_d),
        .q_o     (div_q)
    );

    dffr #(.WIDTH(DIV_VALUE_WIDTH), .RST_VAL('0)) u_shadow_div_ff (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (shadow_div_d),
        .q_o     (shadow_div_q)
    );

    dffr #(.WIDTH(3), .RST_VAL(3'b000)) u_flag_ff (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     ({init_d, shadow_init_d, timeout_d}),
        .q_o     ({init_q, shadow_init_q, timeout_q})
    );

    dffr #(.WIDTH(OUT_W), .RST_VAL(OUT_RST_VAL)) u_out_ff (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     ({clk_en_d, div_valid_d, busy_d, done_d, wait_first_d}),
        .q_o     ({clk_en_q, div_valid_q, busy_q, done_q, wait_first_q})
    );

    clk_div_cfg_tmo_cnt #(.LIMIT(GATE_CYCLES), .WIDTH(GATE_CNT_W)) u_gate_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (state_q != GATE),
        .en_i     (state_q == GATE),
        .expire_o (gate_expire)
    );

    clk_div_cfg_tmo_cnt #(.LIMIT(TIMEOUT_CYCLES), .WIDTH(TMO_CNT_W)) u_tmo_cnt (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (state_q != WAIT_DONE),
        .en_i     (state_q == WAIT_DONE),
        .expire_o (tmo_expire)
    );

    assign div_o       = div_q;
    assign clk_init_o  = init_q;
    assign div_valid_o = div_valid_q;
    assign clk_en_o    = clk_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl: directed and random requests checked against a
// per-request latency/gating model derived from the request rules.
module tb_clk_div_cfg_ctrl;

    localparam int W = 32;
    localparam int G = 2;
    localparam int T = 16;

    logic          clk_i       = 1'b0;
    logic          rst_n_i     = 1'b1;
    logic [W-1:0]  cfg_div_i   = '0;
    logic          cfg_init_i  = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [W-1:0]  div_o;
    logic          clk_init_o;
    logic          div_valid_o;
    logic          div_ready_i = 1'b0;
    logic          div_done_i  = 1'b0;
    logic          clk_en_o;
    logic          busy_o;
    logic          done_o;
    logic          timeout_o;

    int            tests_run    = 0;
    int            tests_failed = 0;

    logic [W-1:0]  model_div  = '0;
    logic          model_init = 1'b0;

    clk_div_cfg_ctrl #(
        .DIV_VALUE_WIDTH (W),
        .DIV_RST_VAL     ('0),
        .GATE_CYCLES     (G),
        .TIMEOUT_CYCLES  (T)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_init_i  (cfg_init_i),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .div_o       (div_o),
        .clk_init_o  (clk_init_o),
        .div_valid_o (div_valid_o),
        .div_ready_i (div_ready_i),
        .div_done_i  (div_done_i),
        .clk_en_o    (clk_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One request. ready_delay: valid cycles with div_ready low; done_delay: cycles after
    // the handshake until div_done rises (<= 0 means never).
    task automatic applyStimulus(input logic [W-1:0] div, input logic init,
                                 input int ready_delay, input int done_delay, input bit poke_busy);
        bit noop;
        bit timeout_exp;
        int wait_cycles;
        int lat_exp;
        int en_low_exp;
        int valid_exp;
        int n;
        int en_low;
        int valid_cnt;
        int busy_low;
        int hs_cycle;
        bit hs_seen;
        bit got_done;

        noop = (div == model_div) && (init == model_init);
        if (done_delay <= 0 || done_delay > T) begin
            wait_cycles = T;
            timeout_exp = 1'b1;
        end else begin
            wait_cycles = (done_delay < 2) ? 2 : done_delay;
            timeout_exp = 1'b0;
        end
        if (noop) begin
            valid_exp   = 0;
            en_low_exp  = 0;
            timeout_exp = 1'b0;
        end else if (div == '0) begin
            valid_exp   = ready_delay + 1;
            en_low_exp  = G + ready_delay + 1;
            timeout_exp = 1'b0;
        end else begin
            valid_exp   = ready_delay + 1;
            en_low_exp  = G + ready_delay + 1 + wait_cycles;
        end
        lat_exp = en_low_exp + 1;

        @(negedge clk_i);
        checkBit("ready_idle", cfg_ready_o, 1'b1);
        cfg_div_i   = div;
        cfg_init_i  = init;
        cfg_valid_i = 1'b1;
        @(posedge clk_i);

        n = 0; en_low = 0; valid_cnt = 0; busy_low = 0; hs_cycle = 0;
        hs_seen = 1'b0; got_done = 1'b0;
        while (!got_done && n < 100) begin
            @(negedge clk_i);
            n++;
            cfg_valid_i = 1'b0;
            if (n == 1) checkBit("timeout_cleared", timeout_o, 1'b0);
            if (poke_busy && n == 2) begin
                checkBit("ready_busy", cfg_ready_o, 1'b0);
                cfg_div_i   = ~div;
                cfg_valid_i = 1'b1;
            end
            if (poke_busy && n == 3) cfg_div_i = div;
            if (!clk_en_o) en_low++;
            if (!busy_o) busy_low++;
            if (div_valid_o) begin
                valid_cnt++;
                if (valid_cnt == 1) checkOutput("div_o_apply", div_o, div);
                div_ready_i = (valid_cnt > ready_delay);
                if (div_ready_i) begin
                    hs_seen  = 1'b1;
                    hs_cycle = n;
                end
            end else begin
                div_ready_i = 1'b0;
            end
            if (hs_seen && n > hs_cycle && done_delay > 0)
                div_done_i = ((n - hs_cycle) >= done_delay);
            if (done_o) got_done = 1'b1;
        end
        div_ready_i = 1'b0;
        div_done_i  = 1'b0;

        checkOutput("latency", n, lat_exp);
        checkOutput("clk_en_low_cycles", en_low, en_low_exp);
        checkOutput("div_valid_cycles", valid_cnt, valid_exp);
        checkOutput("busy_low_in_request", busy_low, 0);

        if (!noop) begin
            model_div  = div;
            model_init = init;
        end

        @(negedge clk_i);
        checkBit("done_single_pulse", done_o, 1'b0);
        checkBit("idle_after", busy_o, 1'b0);
        checkBit("clk_en_after", clk_en_o, 1'b1);
        checkOutput("div_o_after", div_o, model_div);
        checkBit("clk_init_after", clk_init_o, model_init);
        checkBit("timeout_after", timeout_o, timeout_exp);
    endtask

    // Start a request with done never arriving and pull reset while waiting for done.
    task automatic abortInWait(input logic [W-1:0] div);
        bit seen;
        int after;

        seen  = 1'b0;
        after = 0;
        @(negedge clk_i);
        cfg_div_i   = div;
        cfg_init_i  = 1'b1;
        cfg_valid_i = 1'b1;
        @(posedge clk_i);
        for (int k = 0; k < 50 && !(seen && after >= 3); k++) begin
            @(negedge clk_i);
            cfg_valid_i = 1'b0;
            if (seen) after++;
            if (div_valid_o) begin
                seen        = 1'b1;
                div_ready_i = 1'b1;
            end else begin
                div_ready_i = 1'b0;
            end
        end
        div_ready_i = 1'b0;

        checkOutput("pre_reset_div", div_o, div);
        checkBit("pre_reset_clk_en", clk_en_o, 1'b0);
        #1 rst_n_i = 1'b0;
        #1;
        checkOutput("async_reset_div", div_o, 32'd0);
        checkBit("async_reset_clk_en", clk_en_o, 1'b1);
        checkBit("async_reset_busy", busy_o, 1'b0);
        checkBit("async_reset_ready", cfg_ready_o, 1'b1);
        checkBit("async_reset_valid", div_valid_o, 1'b0);
        checkBit("async_reset_init", clk_init_o, 1'b0);
        model_div  = '0;
        model_init = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [W-1:0] r_div;
        logic         r_init;
        int           pick;
        int           r_ready;
        int           r_done;

        #2 rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutput("reset_div", div_o, 32'd0);
        checkBit("reset_clk_en", clk_en_o, 1'b1);
        checkBit("reset_ready", cfg_ready_o, 1'b1);
        checkBit("reset_busy", busy_o, 1'b0);
        checkBit("reset_timeout", timeout_o, 1'b0);
        checkBit("reset_done", done_o, 1'b0);
        checkBit("reset_valid", div_valid_o, 1'b0);
        checkBit("reset_init", clk_init_o, 1'b0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        applyStimulus(32'd3, 1'b0, 0, 5, 1'b0);
        applyStimulus(32'd3, 1'b0, 0, 5, 1'b0);
        applyStimulus(32'd0, 1'b0, 0, 0, 1'b0);
        applyStimulus(32'd7, 1'b0, 0, 0, 1'b0);
        applyStimulus(32'd9, 1'b1, 4, 3, 1'b1);
        applyStimulus(32'd9, 1'b0, 1, 16, 1'b0);
        applyStimulus(32'd12, 1'b0, 0, 1, 1'b0);

        for (int i = 0; i < 14; i++) begin
            pick    = int'($urandom_range(0, 3));
            r_div   = (pick == 0) ? '0 : (pick == 1) ? model_div : W'($urandom_range(1, 15));
            r_init  = 1'($urandom_range(0, 1));
            r_ready = int'($urandom_range(0, 3));
            r_done  = int'($urandom_range(0, 20));
            applyStimulus(r_div, r_init, r_ready, r_done, 1'b0);
        end

        abortInWait(32'd21);
        applyStimulus(32'd4, 1'b1, 2, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
